// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants
// for the external bus target.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        RD_HOLD,
        WR_ARM,
        WR_PULSE,
        WR_DONE,
        ERR_WAIT
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_DUAL_CE  = 3'd1;
    localparam logic [2:0] ERR_OE_WR    = 3'd2;
    localparam logic [2:0] ERR_NO_CE    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_WR_ABORT = 3'd5;

    localparam logic SPACE_PROG = 1'b0;
    localparam logic SPACE_DATA = 1'b1;

endpackage

// File: rtl/ext_bus_chk.sv
// ext_bus_chk: per-cycle strobe violation
// decode plus CE-low timeout counter.
module ext_bus_chk
    import ext_bus_pkg::*;
#(
    parameter int MAX_CYC = 10
) (
    input  logic       Clock_In,
    input  logic       RESET,
    input  logic       pce_n,
    input  logic       dce_n,
    input  logic       oe_n,
    input  logic       wr_n,
    input  logic       cnt_clr,
    output logic [2:0] err
);

    localparam logic [3:0] LIMIT = 4'(MAX_CYC);

    logic       ce_low;
    logic [3:0] cnt;
    logic [3:0] base;
    logic [3:0] cnt_nxt;

    assign ce_low = !pce_n || !dce_n;
    // cnt holds prior consecutive CE-low samples
    assign base = cnt_clr ? 4'd0 : cnt;

    // saturating count of consecutive CE-low samples
    always_comb begin
        cnt_nxt = 4'd0;
        if (ce_low)
            cnt_nxt = (base == 4'hF) ? 4'hF : base + 4'd1;
    end

    // timeout counter register
    always_ff @(posedge Clock_In or posedge RESET) begin
        if (RESET)
            cnt <= 4'd0;
        else
            cnt <= cnt_nxt;
    end

    // prioritised violation decode for this sample
    always_comb begin
        err = ERR_NONE;
        if (!pce_n && !dce_n)
            err = ERR_DUAL_CE;
        else if (!oe_n && !wr_n)
            err = ERR_OE_WR;
        else if (!ce_low && (!oe_n || !wr_n))
            err = ERR_NO_CE;
        else if (ce_low && base >= LIMIT)
            err = ERR_TIMEOUT;
    end

endmodule

// File: rtl/ext_bus_target.sv
// ext_bus_target: turns external bus cycles
// into single-cycle memory port requests.
module ext_bus_target
    import ext_bus_pkg::*;
#(
    parameter int AW      = 16,
    parameter int MAX_CYC = 10
) (
    input  logic          Clock_In,
    input  logic          RESET,
    input  logic          PCE_n,
    input  logic          DCE_n,
    input  logic          OE_n,
    input  logic          WR_n,
    input  logic [AW-1:0] ADDR,
    input  logic [7:0]    DATA_IN,
    output logic [7:0]    DATA_OUT,
    output logic          DATA_OE,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_space,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          err_clr,
    output logic [2:0]    err_code
);

    state_t     state;
    logic [7:0] rd_q;
    logic [7:0] wr_q;
    logic [2:0] chk_err;
    logic [2:0] err_now;
    logic       ce_one;
    logic       all_high;
    logic       space;

    assign ce_one   = PCE_n ^ DCE_n;
    assign all_high = PCE_n && DCE_n && OE_n && WR_n;
    assign space    = !DCE_n ? SPACE_DATA : SPACE_PROG;

    ext_bus_chk #(
        .MAX_CYC(MAX_CYC)
    ) u_chk (
        .Clock_In(Clock_In),
        .RESET   (RESET),
        .pce_n   (PCE_n),
        .dce_n   (DCE_n),
        .oe_n    (OE_n),
        .wr_n    (WR_n),
        .cnt_clr (state == IDLE),
        .err     (chk_err)
    );

    // a CE release mid-write overrides the no-CE strobe error
    always_comb begin
        err_now = chk_err;
        if (state == WR_PULSE && PCE_n && DCE_n)
            err_now = ERR_WR_ABORT;
    end

    // read data: live during RD_DATA, held afterwards
    always_comb begin
        DATA_OUT = 8'h00;
        case (state)
            RD_DATA: DATA_OUT = mem_rdata;
            RD_HOLD: DATA_OUT = rd_q;
            default: DATA_OUT = 8'h00;
        endcase
    end

    // bus cycle FSM with registered outputs
    always_ff @(posedge Clock_In or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            DATA_OE   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_space <= SPACE_PROG;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            err_code  <= ERR_NONE;
            rd_q      <= 8'h00;
            wr_q      <= 8'h00;
        end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!WR_n)
                wr_q <= DATA_IN;
            if (err_now != ERR_NONE &&
                (err_code == ERR_NONE || err_clr))
                err_code <= err_now;
            else if (err_clr)
                err_code <= ERR_NONE;
            if (err_now != ERR_NONE) begin
                DATA_OE <= 1'b0;
                state   <= ERR_WAIT;
            end else begin
                case (state)
                    IDLE, WR_ARM: begin
                        if (ce_one) begin
                            mem_addr  <= ADDR;
                            mem_space <= space;
                            if (!OE_n) begin
                                mem_req <= 1'b1;
                                state   <= RD_ISSUE;
                            end else if (!WR_n) begin
                                state <= WR_PULSE;
                            end else begin
                                state <= WR_ARM;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RD_ISSUE: begin
                        DATA_OE <= 1'b1;
                        state   <= RD_DATA;
                    end
                    RD_DATA: begin
                        rd_q  <= mem_rdata;
                        state <= RD_HOLD;
                    end
                    RD_HOLD: begin
                        if (!ce_one || OE_n) begin
                            DATA_OE <= 1'b0;
                            state   <= all_high ? IDLE : ERR_WAIT;
                        end
                    end
                    WR_PULSE: begin
                        if (WR_n) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= wr_q;
                            state     <= WR_DONE;
                        end
                    end
                    WR_DONE: begin
                        if (!ce_one)
                            state <= IDLE;
                    end
                    ERR_WAIT: begin
                        if (all_high)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_target.sv
// tb_ext_bus_target: directed bus cycles with a
// scoreboard of expected memory requests.
module tb_ext_bus_target;

    typedef struct packed {
        logic        we;
        logic        sp;
        logic [15:0] addr;
        logic [7:0]  wd;
    } txn_t;

    logic        Clock_In = 1'b0;
    logic        RESET    = 1'b1;
    logic        PCE_n    = 1'b1;
    logic        DCE_n    = 1'b1;
    logic        OE_n     = 1'b1;
    logic        WR_n     = 1'b1;
    logic [15:0] ADDR     = 16'h0000;
    logic [7:0]  DATA_IN  = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic        err_clr  = 1'b0;
    logic [7:0]  DATA_OUT;
    logic        DATA_OE;
    logic        mem_req;
    logic        mem_we;
    logic        mem_space;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [2:0]  err_code;

    int   errors = 0;
    int   checks = 0;
    txn_t sb[$];
    logic prev_req = 1'b0;

    ext_bus_target #(
        .AW     (16),
        .MAX_CYC(10)
    ) dut (
        .Clock_In (Clock_In),
        .RESET    (RESET),
        .PCE_n    (PCE_n),
        .DCE_n    (DCE_n),
        .OE_n     (OE_n),
        .WR_n     (WR_n),
        .ADDR     (ADDR),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .DATA_OE  (DATA_OE),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_space(mem_space),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err_clr  (err_clr),
        .err_code (err_code)
    );

    always #5 Clock_In = ~Clock_In;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic expect_txn(input logic we, input logic sp,
                              input logic [15:0] a,
                              input logic [7:0] d);
        txn_t t;
        t.we = we;
        t.sp = sp;
        t.addr = a;
        t.wd = d;
        sb.push_back(t);
    endtask

    // scoreboard: compare each request pulse against the queue
    always @(negedge Clock_In) begin
        txn_t t;
        if (mem_req) begin
            if (prev_req)
                check("req_back2back", 32'(mem_req), 0);
            if (sb.size() == 0) begin
                check("req_unexpected", 32'(mem_req), 0);
            end else begin
                t = sb.pop_front();
                check("req_we", 32'(mem_we), 32'(t.we));
                check("req_space", 32'(mem_space), 32'(t.sp));
                check("req_addr", 32'(mem_addr), 32'(t.addr));
                if (t.we)
                    check("req_wdata", 32'(mem_wdata), 32'(t.wd));
            end
        end
        prev_req = mem_req;
    end

    initial begin
        #2;
        check("rst_oe", 32'(DATA_OE), 0);
        check("rst_dout", 32'(DATA_OUT), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_err", 32'(err_code), 0);
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // program read, 7 samples low
        ADDR = 16'h1234;
        mem_rdata = 8'hA5;
        PCE_n = 1'b0;
        OE_n = 1'b0;
        expect_txn(1'b0, 1'b0, 16'h1234, 8'h00);
        tick();
        check("rd_oe_e0", 32'(DATA_OE), 0);
        for (int i = 1; i < 7; i++) begin
            tick();
            check("rd_oe", 32'(DATA_OE), 1);
            check("rd_dout", 32'(DATA_OUT), 'hA5);
            if (i == 2)
                mem_rdata = 8'h5A;
        end
        PCE_n = 1'b1;
        OE_n = 1'b1;
        tick();
        check("rd_oe_fall", 32'(DATA_OE), 0);
        check("rd_err", 32'(err_code), 0);

        // data write, last byte under WR_n low wins
        DCE_n = 1'b0;
        ADDR = 16'h0042;
        tick();
        WR_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DATA_IN = (i == 4) ? 8'h3C : 8'(8'h11 + i);
            tick();
            check("wr_noreq", 32'(mem_req), 0);
        end
        expect_txn(1'b1, 1'b1, 16'h0042, 8'h3C);
        WR_n = 1'b1;
        DATA_IN = 8'hFF;
        tick();
        check("wr_req", 32'(mem_req), 1);
        check("wr_we", 32'(mem_we), 1);
        tick();
        check("wr_req_once", 32'(mem_req), 0);
        DCE_n = 1'b1;
        tick();
        check("wr_err", 32'(err_code), 0);

        // dual CE error, then a read is still served
        PCE_n = 1'b0;
        DCE_n = 1'b0;
        OE_n = 1'b0;
        tick();
        check("dual_err", 32'(err_code), 1);
        check("dual_oe", 32'(DATA_OE), 0);
        tick();
        check("dual_sticky", 32'(err_code), 1);
        PCE_n = 1'b1;
        DCE_n = 1'b1;
        OE_n = 1'b1;
        tick();
        ADDR = 16'h0777;
        mem_rdata = 8'h3E;
        PCE_n = 1'b0;
        OE_n = 1'b0;
        expect_txn(1'b0, 1'b0, 16'h0777, 8'h00);
        tick();
        tick();
        check("rd2_oe", 32'(DATA_OE), 1);
        check("rd2_dout", 32'(DATA_OUT), 'h3E);
        tick();
        PCE_n = 1'b1;
        OE_n = 1'b1;
        tick();
        check("rd2_oe_fall", 32'(DATA_OE), 0);
        check("rd2_err_kept", 32'(err_code), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr1", 32'(err_code), 0);

        // CE timeout: error on the 11th sample
        DCE_n = 1'b0;
        for (int i = 1; i <= 10; i++)
            tick();
        check("to_10", 32'(err_code), 0);
        tick();
        check("to_11", 32'(err_code), 4);
        DCE_n = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr4", 32'(err_code), 0);

        // aborted write
        DCE_n = 1'b0;
        tick();
        WR_n = 1'b0;
        DATA_IN = 8'h77;
        tick();
        tick();
        DCE_n = 1'b1;
        tick();
        check("abort_err", 32'(err_code), 5);
        check("abort_req", 32'(mem_req), 0);
        WR_n = 1'b1;
        tick();
        check("abort_sticky", 32'(err_code), 5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr5", 32'(err_code), 0);

        // reset in the middle of a write pulse
        ADDR = 16'hBEEF;
        DCE_n = 1'b0;
        WR_n = 1'b0;
        DATA_IN = 8'h99;
        tick();
        tick();
        check("pre_rst_addr", 32'(mem_addr), 'hBEEF);
        #2;
        RESET = 1'b1;
        #1;
        check("mrst_addr", 32'(mem_addr), 0);
        check("mrst_space", 32'(mem_space), 0);
        check("mrst_oe", 32'(DATA_OE), 0);
        DCE_n = 1'b1;
        WR_n = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        check("mrst_err", 32'(err_code), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_bus_target.md
# ext_bus_target

Responder (target) end of the CPU external bus. It decodes the PCE_n/DCE_n/OE_n/WR_n strobes issued by the bus controller and turns each bus cycle into a single-cycle request on a synchronous program/data memory port. For reads it drives the returned byte onto the bus. For writes it captures the CPU byte and commits it on WR_n release. It also checks every cycle for protocol violations and reports them through a sticky error code. It sits between the external bus pins and the board-level program/data memory model or arbiter.

## Interface
- AW, 16, address width of ADDR and mem_addr.
- MAX_CYC, 10, maximum legal number of consecutive Clock_In samples with a CE strobe low.
- Clock_In  in  1  clock, same clock that drives the bus controller.
- RESET  in  1  reset, asynchronous, active-high.
- PCE_n, DCE_n  in  1  program / data chip enable, active-low.
- OE_n, WR_n  in  1  output enable / write strobe, active-low.
- ADDR  in  AW  bus address, stable while CE is low.
- DATA_IN  in  8  CPU write data.
- DATA_OUT  out  8  read data to CPU.
- DATA_OE  out  1  read-data drive enable.
- mem_req  out  1  one-cycle memory request pulse.
- mem_we  out  1  write qualifier for mem_req.
- mem_space  out  1  address space: 0 = program, 1 = data.
- mem_addr  out  AW  request address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid the cycle after mem_req.
- err_clr  in  1  synchronous clear of the error code.
- err_code  out  3  sticky first error code; 0 = none.

## Operation
- All strobes are sampled on posedge Clock_In. A CE is "active" when exactly one of PCE_n/DCE_n is sampled low.
- FSM states: IDLE, RD_ISSUE, RD_DATA, RD_HOLD, WR_ARM, WR_PULSE, WR_DONE, ERR_WAIT.
- IDLE, CE active and OE_n low: latch ADDR and space into mem_addr/mem_space, pulse mem_req=1 with mem_we=0, go to RD_ISSUE.
- IDLE, CE active, OE_n high, WR_n high: go to WR_ARM.
- IDLE, CE active, WR_n low: go to WR_PULSE.
- RD_ISSUE: set DATA_OE=1, go to RD_DATA.
- RD_DATA: DATA_OUT = mem_rdata combinationally; rd_q <= mem_rdata; go to RD_HOLD.
- RD_HOLD: DATA_OUT = rd_q. When CE or OE_n is sampled high, clear DATA_OE; return to IDLE when all strobes are high, otherwise go to ERR_WAIT.
- WR_ARM: when WR_n is sampled low, go to WR_PULSE.
- WR_PULSE: capture DATA_IN into wr_q every cycle.
  - WR_n sampled high with CE still low: pulse mem_req=1, mem_we=1, mem_wdata=wr_q (the last byte sampled while WR_n was low); go to WR_DONE.
  - CE sampled high: error 5, no commit.
- WR_DONE: when CE is sampled high, go to IDLE.
- Error codes are checked in every state; on error, clear DATA_OE and go to ERR_WAIT without issuing or committing a request.
  - 1: PCE_n and DCE_n both low.
  - 2: OE_n and WR_n both low.
  - 3: OE_n or WR_n low while both CEs are high.
  - 4: CE low for more than MAX_CYC samples, counted by a 4-bit saturating counter cleared in IDLE.
  - 5: write aborted.
- ERR_WAIT: return to IDLE once all four strobes are sampled high.
- err_code latches only the first error. err_clr zeroes it; an error occurring in the same cycle as err_clr wins.

## Timing
- Reset values: DATA_OUT=0, DATA_OE=0, mem_req=0, mem_we=0, mem_space=0, mem_addr=0, mem_wdata=0, err_code=0, FSM=IDLE, counter=0.
- Reset mid-cycle aborts with no commit. After reset, a cycle whose strobes are already low is treated as error 3 or normal according to the first samples taken.
- Read path, with e0 = the first edge sampling CE+OE low:
  - mem_req is high for the cycle after e0.
  - DATA_OE rises after e1, and DATA_OUT is valid from after e1.
  - For the standard controller cycle (strobes low for 7 samples), data is stable before the CPUClock rising edge at controller state 3.
  - DATA_OE falls on the first edge sampling OE_n or CE high.
- Write commit: mem_req/mem_we rise on the edge that first samples WR_n high, for exactly one cycle.
- mem_req never asserts for two consecutive cycles, and never more than once per bus cycle.

## Structure
- Shared package ext_bus_pkg holds:
  - the FSM state enum;
  - error code constants ERR_NONE, ERR_DUAL_CE, ERR_OE_WR, ERR_NO_CE, ERR_TIMEOUT, ERR_WR_ABORT;
  - SPACE_PROG/SPACE_DATA.
- Sub-module ext_bus_chk is natural: a combinational violation decode plus the timeout counter, exporting a per-cycle error code. The FSM and datapath stay in ext_bus_target.

## Test plan
- PCE_n/OE_n low for 7 cycles, ADDR=0x1234, mem_rdata=0xA5 -> one read pulse with space=0, addr=0x1234; DATA_OE=1 with DATA_OUT=0xA5 from e1 until OE_n is sampled high.
- DCE_n low, then WR_n low for 5 cycles with DATA_IN=0x3C, WR_n released before DCE_n -> single pulse with mem_we=1, space=1, wdata=0x3C, on the edge sampling WR_n high.
- PCE_n and DCE_n both low -> err_code=1, no mem_req, DATA_OE=0; all strobes high, then a normal read -> served.
- DCE_n low for 11 samples with no OE/WR -> err_code=4 at sample 11.
- DCE_n raised while WR_n low -> err_code=5, no write pulse; err_clr -> err_code=0.
- RESET asserted during WR_PULSE -> all outputs reach their reset values immediately and no write occurs.
